// File: rtl/pulse_meter.sv
// Pulse-train receiver: synchronizes an asynchronous input, groups pulses into
// idle-terminated bursts, and reports count, last width and last period.
module pulse_meter #(
  parameter int CW           = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          signal,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic [CW-1:0] high_width,
  output logic [CW-1:0] period,
  output logic          done,
  output logic          busy,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX     = '1;
  localparam logic [CW-1:0] TIMEOUT = CW'(IDLE_TIMEOUT);

  state_t        state, state_next;
  logic          s1, s2, s3;
  logic          rise, fall;
  logic [CW-1:0] pcnt, pcnt_next;
  logic [CW-1:0] wcnt, wcnt_next;
  logic [CW-1:0] prd_cnt, prd_next;
  logic [CW-1:0] last_prd, last_next;
  logic [CW-1:0] idle_cnt, idle_next;
  logic          sat, sat_next;
  logic          finish;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      wcnt     <= '0;
      prd_cnt  <= '0;
      last_prd <= '0;
      idle_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      wcnt     <= wcnt_next;
      prd_cnt  <= prd_next;
      last_prd <= last_next;
      idle_cnt <= idle_next;
      sat      <= sat_next;
    end
  end

  always_comb begin
    state_next = state;
    pcnt_next  = pcnt;
    wcnt_next  = wcnt;
    prd_next   = prd_cnt;
    last_next  = last_prd;
    idle_next  = idle_cnt;
    sat_next   = sat;
    finish     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      pcnt_next  = '0;
      wcnt_next  = '0;
      prd_next   = '0;
      last_next  = '0;
      idle_next  = '0;
      sat_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = HIGH;
            pcnt_next  = ONE;
            wcnt_next  = ONE;
            prd_next   = ONE;
            last_next  = '0;
            idle_next  = '0;
            sat_next   = 1'b0;
          end
        end
        HIGH: begin
          // The period keeps running on the falling cycle; the width does not,
          // so a pulse seen on W edges reports exactly W.
          prd_next = sat_inc(prd_cnt);
          if (prd_cnt == MAX) sat_next = 1'b1;
          if (fall) begin
            state_next = LOW;
            idle_next  = ONE;
          end else begin
            wcnt_next = sat_inc(wcnt);
            if (wcnt == MAX) sat_next = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_next = HIGH;
            last_next  = prd_cnt;
            prd_next   = ONE;
            wcnt_next  = ONE;
            pcnt_next  = sat_inc(pcnt);
            if (pcnt == MAX) sat_next = 1'b1;
          end else begin
            prd_next  = sat_inc(prd_cnt);
            idle_next = sat_inc(idle_cnt);
            if (prd_cnt == MAX) sat_next = 1'b1;
            if (idle_cnt == TIMEOUT) begin
              state_next = IDLE;
              finish     = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done       <= 1'b0;
      count      <= '0;
      high_width <= '0;
      period     <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        count      <= pcnt;
        high_width <= wcnt;
        period     <= last_prd;
        overflow   <= sat;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: burst, single pulse, saturation, gap
// boundary, reset mid-burst and enable drop, with hand-computed results.
module tb_pulse_meter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       signal;
  logic       enable;
  logic [7:0] count;
  logic [7:0] high_width;
  logic [7:0] period;
  logic       done;
  logic       busy;
  logic       overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] hw;
    logic [7:0] prd;
    logic       ovf;
  } res_t;

  res_t q[$];

  pulse_meter #(.CW(8), .IDLE_TIMEOUT(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .signal     (signal),
    .enable     (enable),
    .count      (count),
    .high_width (high_width),
    .period     (period),
    .done       (done),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done) q.push_back('{cnt: count, hw: high_width, prd: period, ovf: overflow});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int unsigned n);
    signal = lvl;
    repeat (n) @(negedge clock);
  endtask

  task automatic get_result(input string tag, output res_t r);
    int unsigned n = 0;
    while (q.size() == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, (q.size() != 0), 1);
    if (q.size() != 0) r = q.pop_front();
    else r = '{cnt: '0, hw: '0, prd: '0, ovf: 1'b0};
  endtask

  task automatic check_res(input string tag, input res_t r, input int c, input int w,
                           input int p, input int o);
    check({tag, "_count"}, r.cnt, c);
    check({tag, "_width"}, r.hw, w);
    check({tag, "_period"}, r.prd, p);
    check({tag, "_overflow"}, r.ovf, o);
  endtask

  initial begin
    res_t        r;
    int unsigned lat;

    reset_n = 1'b0;
    signal  = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_count", count, 0);
    check("rst_width", high_width, 0);
    check("rst_period", period, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (3) @(negedge clock);

    // Three pulses, high 3, period 8
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    check("burst_busy", busy, 1);
    get_result("burst3", r);
    check_res("burst3", r, 3, 3, 8, 0);
    check("burst3_idle", busy, 0);

    // Single pulse with done latency from first low sample
    repeat (4) @(negedge clock);
    drive(1'b1, 5);
    signal = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(negedge clock);
      lat++;
      if (done) break;
    end
    check("single_latency", lat, 19);
    @(negedge clock);
    check("single_done_one_cycle", done, 0);
    get_result("single", r);
    check_res("single", r, 1, 5, 0, 0);

    // Gap of exactly 16 low cycles keeps one burst
    repeat (4) @(negedge clock);
    drive(1'b1, 3);
    drive(1'b0, 16);
    drive(1'b1, 3);
    signal = 1'b0;
    get_result("gap16", r);
    check_res("gap16", r, 2, 3, 19, 0);

    // Gap of 17 low cycles splits into two bursts
    repeat (4) @(negedge clock);
    drive(1'b1, 3);
    drive(1'b0, 17);
    drive(1'b1, 4);
    signal = 1'b0;
    get_result("gap17_a", r);
    check_res("gap17_a", r, 1, 3, 0, 0);
    get_result("gap17_b", r);
    check_res("gap17_b", r, 1, 4, 0, 0);

    // Saturation
    repeat (4) @(negedge clock);
    drive(1'b1, 300);
    signal = 1'b0;
    get_result("sat", r);
    check_res("sat", r, 1, 255, 0, 1);
    check("sat_out_width", high_width, 255);
    check("sat_out_overflow", overflow, 1);

    // Reset during the second pulse
    repeat (4) @(negedge clock);
    drive(1'b1, 3);
    drive(1'b0, 5);
    signal = 1'b1;
    repeat (2) @(negedge clock);
    check("mid_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_width", high_width, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    signal = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 2);
    check("mid_rst_no_done", q.size(), 0);
    drive(1'b1, 2);
    signal = 1'b0;
    get_result("post_rst", r);
    check_res("post_rst", r, 1, 2, 0, 0);

    // Enable drop mid-burst
    repeat (4) @(negedge clock);
    drive(1'b1, 3);
    drive(1'b0, 2);
    signal = 1'b1;
    repeat (2) @(negedge clock);
    check("en_busy_before", busy, 1);
    enable = 1'b0;
    @(negedge clock);
    check("en_busy_after", busy, 0);
    signal = 1'b0;
    repeat (40) @(negedge clock);
    check("en_no_done", q.size(), 0);
    check("en_count_kept", count, 1);
    check("en_width_kept", high_width, 2);
    check("en_period_kept", period, 0);
    check("en_overflow_kept", overflow, 0);
    enable = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Synchronous receiver for the pulse and trigger trains produced by the test-pulse generators. It samples an asynchronous `signal` input through a 2-flop synchronizer and groups consecutive pulses into bursts that end after an idle timeout. For each burst it reports the pulse count, the width of the last pulse, and the rising-to-rising period of the last two pulses. It sits on the measurement side of the test benches and replaces manual waveform inspection.

## Interface
- `CW`, default 8: width of every counter and result output.
- `IDLE_TIMEOUT`, default 16: number of low cycles that ends a burst. Legal range is 2 to 2^CW−1.
- `clock`  input  1: sole clock; everything is sampled on the posedge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `signal`  input  1: asynchronous pulse input.
- `enable`  input  1: measurement enable, synchronous to `clock`.
- `count`  output  CW: number of pulses in the last completed burst.
- `high_width`  output  CW: high time of the last pulse in that burst, in clock cycles.
- `period`  output  CW: rising-to-rising time of the last two pulses; 0 if the burst had one pulse.
- `done`  output  1: one-cycle strobe; results are updated in the same cycle.
- `busy`  output  1: high while a burst is in progress.
- `overflow`  output  1: high if any counter saturated in the last completed burst.

## Operation
- Synchronizer chain: `s1<=signal`, `s2<=s1`, `s3<=s2`.
  - `rise = s2 & ~s3`
  - `fall = ~s2 & s3`
- FSM states: IDLE, HIGH, LOW. `busy` = (state != IDLE).
- **IDLE:**
  - On `rise` with `enable`=1: go to HIGH, `pcnt<=1`, `wcnt<=1`, `prd_cnt<=1`, `last_prd<=0`, clear the internal sat flag.
- **HIGH:**
  - `wcnt` and `prd_cnt` increment each cycle.
  - On `fall`: go to LOW, `idle_cnt<=1`.
- **LOW:**
  - `prd_cnt` and `idle_cnt` increment each cycle.
  - On `rise`: go to HIGH, `last_prd<=prd_cnt`, `prd_cnt<=1`, `wcnt<=1`, `pcnt<=pcnt+1`.
  - Otherwise, when `idle_cnt==IDLE_TIMEOUT`: go to IDLE and register `done<=1` together with `count<=pcnt`, `high_width<=wcnt`, `period<=last_prd`, `overflow<=sat`.
- **Saturation:** all counters saturate at 2^CW−1 and never wrap. Any saturation sets the internal sat flag for the current burst.
- **`enable`=0 in any state:** go to IDLE next edge and clear the working counters. No `done` is produced, and the result outputs keep their previous values.
- **Rise and timeout in the same cycle:** rise wins and the burst continues.
- **Reset:** all state, counters, synchronizer flops and outputs go to 0 immediately. The FSM returns to IDLE; a partial burst is discarded.

## Timing
- All outputs are 0 at reset. `done` is high for exactly one cycle per completed burst.
- **Latency to FSM:** an input edge first sampled at clock edge N changes the FSM state at edge N+2.
- **Width:** a pulse sampled high on exactly W consecutive edges gives `high_width`=W.
- **Period:** rising samples P edges apart give `period`=P.
- **Burst end:** if the last falling level is first sampled at edge M and no rise follows, `done` rises at edge M+IDLE_TIMEOUT+2.
- **Gap rule:**
  - A low gap of L ≤ IDLE_TIMEOUT sampled cycles continues the burst.
  - A gap of L = IDLE_TIMEOUT+1 or more ends it.
- Results stay stable between `done` strobes.

## Test plan
- **Three-pulse burst:** CW=8, IDLE_TIMEOUT=16; 3 pulses, each high 3 cycles, period 8 → one `done` with `count`=3, `high_width`=3, `period`=8, `overflow`=0.
- **Single pulse:** high 5 cycles → `count`=1, `high_width`=5, `period`=0; `done` exactly 16+2 cycles after the first low sample.
- **Saturation:** `signal` high for 300 cycles, then low → `high_width`=255, `overflow`=1.
- **Gap boundary:**
  - Two pulses separated by exactly 16 low cycles → one burst, `count`=2.
  - Separated by 17 low cycles → two `done` strobes, each with `count`=1.
- **Reset mid-burst:** assert `reset_n`=0 during the 2nd pulse → all outputs 0 immediately. After release, a fresh 1-pulse burst reports `count`=1.
- **Enable drop:** deassert `enable` mid-burst → `busy` falls next edge, no `done`, and prior results are unchanged.
